// File: rtl/sram_controller.sv
// Bridges a 32-bit load/store pipeline port onto a 16-bit asynchronous SRAM,
// splitting each access into a low and a high halfword phase of HOLD cycles each.
module sram_controller #(
    parameter int HOLD = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        ready,
    output logic [17:0] SRAM_ADDR,
    output logic [15:0] SRAM_DQ_out,
    input  logic [15:0] SRAM_DQ_in,
    output logic        SRAM_DQ_oe,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    localparam int CW = $clog2(HOLD + 1);
    localparam logic [CW-1:0] LAST = CW'(HOLD - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [16:0]   word_addr;
    logic [15:0]   data_hi;
    logic          op_write;

    // Only the word-select bits of the byte address reach the SRAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{address[31:19], address[1:0]};

    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

    // Pin outputs are registered alongside the state so each phase's values
    // appear exactly in the cycles that phase occupies.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            word_addr   <= '0;
            data_hi     <= '0;
            op_write    <= 1'b0;
            readData    <= '0;
            SRAM_ADDR   <= '0;
            SRAM_DQ_out <= '0;
            SRAM_DQ_oe  <= 1'b0;
            SRAM_WE_N   <= 1'b1;
            SRAM_OE_N   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_en || rd_en) begin
                        word_addr   <= address[18:2];
                        data_hi     <= writeData[31:16];
                        op_write    <= wr_en;
                        count       <= '0;
                        state       <= LOW;
                        SRAM_ADDR   <= {address[18:2], 1'b0};
                        SRAM_DQ_out <= wr_en ? writeData[15:0] : 16'h0000;
                        SRAM_DQ_oe  <= wr_en;
                        SRAM_WE_N   <= ~wr_en;
                        SRAM_OE_N   <= wr_en;
                    end
                end
                LOW: begin
                    if (count == LAST) begin
                        if (!op_write) begin
                            readData[15:0] <= SRAM_DQ_in;
                        end
                        count       <= '0;
                        state       <= HIGH;
                        SRAM_ADDR   <= {word_addr, 1'b1};
                        SRAM_DQ_out <= op_write ? data_hi : 16'h0000;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                HIGH: begin
                    if (count == LAST) begin
                        if (!op_write) begin
                            readData[31:16] <= SRAM_DQ_in;
                        end
                        count       <= '0;
                        state       <= DONE;
                        SRAM_ADDR   <= '0;
                        SRAM_DQ_out <= '0;
                        SRAM_DQ_oe  <= 1'b0;
                        SRAM_WE_N   <= 1'b1;
                        SRAM_OE_N   <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // A request arriving in IDLE freezes the pipeline in the same cycle.
    always_comb begin
        ready = 1'b0;
        if (state == DONE) begin
            ready = 1'b1;
        end else if (state == IDLE) begin
            ready = ~(wr_en | rd_en);
        end
    end

endmodule
